pwm_button_array: RTL and testbench

Multi-channel PWM generator with per-channel push-button duty control. It extends the single-channel button-driven PWM to a parametrised channel count, period and step size, and adds glitch-free duty updates at period boundaries plus saturating arithmetic. It sits between raw board buttons and LED or motor-driver outputs; the buttons are sampled on a divided "slow" tick for debounce.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/btn_press_detect.sv | 30 +++
 rtl/pwm_button_array.sv | 143 ++++++++++++++
 tb/tb_pwm_button_array.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and saturating helpers for the button-driven PWM array.
// Saturating helpers work at 32 bits, far wider than any duty value, so the
// intermediate sum or difference can never wrap before the clamp is applied.
package pwm_pkg;

  localparam int PWM_PERIOD_DEF    = 10;
  localparam int PWM_STEP_DEF      = 2;
  localparam int PWM_TICK_DIV_DEF  = 2**20;
  localparam int PWM_DUTY_INIT_DEF = 5;

  // Add a step and clamp at the ceiling.
  function automatic int unsigned sat_add(input int unsigned val,
                                          input int unsigned step,
                                          input int unsigned ceil);
    int unsigned sum;
    sum = val + step;
    return (sum > ceil) ? ceil : sum;
  endfunction

  // Subtract a step and clamp at zero.
  function automatic int unsigned sat_sub(input int unsigned val,
                                          input int unsigned step);
    return (val < step) ? 32'd0 : (val - step);
  endfunction

endpackage

// File: rtl/btn_press_detect.sv
// Debounced press detector for one raw push-button.
// The button is sampled only on the slow tick; a press is one tick-wide pulse
// on the first tick after the sampled level rises, however long it is held.
module btn_press_detect
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic s1;
  logic s2;

  // Two-flop sampler advanced only on the slow tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (tick) begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  assign press = s1 & ~s2 & tick;

endmodule

// File: rtl/pwm_button_array.sv
// Multi-channel PWM generator with per-channel inc/dec push-button duty control.
// Button presses update a pending duty; the active duty is loaded from it only
// at the last count of a period, so a running period is never truncated.
// Optional build macro PWM_PHASE_STAGGER_EN: channel k compares a counter phase
// advanced by k*(PERIOD/CH) to spread rising edges; the shadow load still
// happens at the global wrap. Undefined: every channel compares cnt directly.
module pwm_button_array
  import pwm_pkg::*;
#(
  parameter int CH        = 4,
  parameter int PERIOD    = PWM_PERIOD_DEF,
  parameter int STEP      = PWM_STEP_DEF,
  parameter int DUTY_INIT = PWM_DUTY_INIT_DEF,
  parameter int TICK_DIV  = PWM_TICK_DIV_DEF,
  parameter int DUTY_W    = $clog2(PERIOD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH-1:0]        btn_inc,
  input  logic [CH-1:0]        btn_dec,
  output logic [CH-1:0]        pwm,
  output logic [CH*DUTY_W-1:0] duty,
  output logic                 period_start
);

  localparam int                DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_INIT);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [DUTY_W-1:0] cnt;
  logic [CH-1:0]     inc_press;
  logic [CH-1:0]     dec_press;
  logic [DUTY_W-1:0] pend  [CH];
  logic [DUTY_W-1:0] act   [CH];
  logic [DUTY_W-1:0] phase [CH];
  logic [CH-1:0]     cmp_p0;

  // Slow tick divider shared by every button sampler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // Period counter shared by all channels, wraps 0..PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  for (genvar k = 0; k < CH; k++) begin : g_btn
    btn_press_detect u_inc (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn   (btn_inc[k]),
      .press (inc_press[k])
    );
    btn_press_detect u_dec (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .btn   (btn_dec[k]),
      .press (dec_press[k])
    );
  end

  // Pending duty: saturating step on a lone inc or dec press; both cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) pend[k] <= DUTY_RST;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (inc_press[k] && !dec_press[k])
          pend[k] <= DUTY_W'(sat_add(32'(pend[k]), STEP, PERIOD));
        else if (dec_press[k] && !inc_press[k])
          pend[k] <= DUTY_W'(sat_sub(32'(pend[k]), STEP));
      end
    end
  end

  // Active duty shadow-loads from pending on the last count of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) act[k] <= DUTY_RST;
    end else if (cnt == CNT_LAST) begin
      for (int k = 0; k < CH; k++) act[k] <= pend[k];
    end
  end

`ifdef PWM_PHASE_STAGGER_EN
  localparam logic [DUTY_W:0] PERIOD_X = (DUTY_W+1)'(PERIOD);

  // Counter advanced by channel k's fixed offset, folded back into 0..PERIOD-1.
  function automatic logic [DUTY_W-1:0] wrap_phase(input logic [DUTY_W-1:0] c,
                                                   input int k);
    logic [DUTY_W:0] sum;
    sum = {1'b0, c} + (DUTY_W+1)'((k * (PERIOD / CH)) % PERIOD);
    if (sum >= PERIOD_X) sum = sum - PERIOD_X;
    return sum[DUTY_W-1:0];
  endfunction

  // Per-channel staggered compare phase.
  always_comb begin
    for (int k = 0; k < CH; k++) phase[k] = wrap_phase(cnt, k);
  end
`else
  // All channels compare the shared counter directly.
  always_comb begin
    for (int k = 0; k < CH; k++) phase[k] = cnt;
  end
`endif

  // Stage p0: duty compare against the current phase.
  always_comb begin
    cmp_p0 = '0;
    for (int k = 0; k < CH; k++) cmp_p0[k] = (phase[k] < act[k]);
  end

  // Stage p1: registered outputs; period_start marks the cnt=0 compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm          <= '0;
      period_start <= 1'b0;
    end else begin
      pwm          <= cmp_p0;
      period_start <= (cnt == '0);
    end
  end

  // Pack the active duties onto the flat output bus.
  always_comb begin
    duty = '0;
    for (int k = 0; k < CH; k++) duty[k*DUTY_W +: DUTY_W] = act[k];
  end

endmodule

// File: tb/tb_pwm_button_array.sv
// Self-checking bench for pwm_button_array (CH=2, PERIOD=10, STEP=2,
// DUTY_INIT=5, TICK_DIV=4). Stimulus pushes expected duties into a queue;
// a monitor pops one at each period_start, compares the duty bus and then
// the number of pwm-high cycles over that whole period.
module tb_pwm_button_array;

  localparam int CH        = 2;
  localparam int PERIOD    = 10;
  localparam int STEP      = 2;
  localparam int DUTY_INIT = 5;
  localparam int TICK_DIV  = 4;
  localparam int DW        = $clog2(PERIOD + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   btn_inc = '0;
  logic [CH-1:0]   btn_dec = '0;
  logic [CH-1:0]   pwm;
  logic [CH*DW-1:0] duty;
  logic            period_start;

  pwm_button_array #(
    .CH(CH), .PERIOD(PERIOD), .STEP(STEP), .DUTY_INIT(DUTY_INIT), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .pwm(pwm), .duty(duty), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d0; logic [7:0] d1; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int mdl [CH];

  // monitor state
  bit armed = 1'b0;
  bit seen  = 1'b0;
  int a0, a1, hi0, hi1, gap;

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  function automatic int m_inc(input int d);
    return (d + STEP > PERIOD) ? PERIOD : d + STEP;
  endfunction

  function automatic int m_dec(input int d);
    return (d < STEP) ? 0 : d - STEP;
  endfunction

  // Monitor: scores every completed period and consumes expected duties.
  always @(negedge clk) begin
    if (!rst_n) begin
      armed = 1'b0;
      seen  = 1'b0;
    end else if (period_start) begin
      if (armed) begin
        chk("pwm0_high_count", hi0, a0);
        chk("pwm1_high_count", hi1, a1);
        armed = 1'b0;
      end
      if (seen) chk("period_len", gap, PERIOD);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("duty0", int'(duty[DW-1:0]), int'(e.d0));
        chk("duty1", int'(duty[2*DW-1:DW]), int'(e.d1));
        a0 = int'(e.d0);
        a1 = int'(e.d1);
        armed = 1'b1;
      end
      hi0  = int'(pwm[0]);
      hi1  = int'(pwm[1]);
      gap  = 1;
      seen = 1'b1;
    end else begin
      hi0 += int'(pwm[0]);
      hi1 += int'(pwm[1]);
      gap++;
    end
  end

  task automatic push_and_drain(input string name);
    int w;
    exp_t e;
    e.d0 = 8'(mdl[0]);
    e.d1 = 8'(mdl[1]);
    exp_q.push_back(e);
    w = 0;
    while ((exp_q.size() != 0 || armed) && w < 4 * PERIOD) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4 * PERIOD) chk({name, "_drain_timeout"}, w, 4 * PERIOD - 1);
  endtask

  // Press the masked buttons for hold ticks, release, update the model.
  task automatic press(input logic [CH-1:0] im, input logic [CH-1:0] dm, input int hold);
    @(negedge clk);
    btn_inc = im;
    btn_dec = dm;
    repeat (hold * TICK_DIV) @(negedge clk);
    btn_inc = '0;
    btn_dec = '0;
    repeat (3 * TICK_DIV) @(negedge clk);
    for (int k = 0; k < CH; k++) begin
      if (im[k] && !dm[k])      mdl[k] = m_inc(mdl[k]);
      else if (dm[k] && !im[k]) mdl[k] = m_dec(mdl[k]);
    end
    repeat (PERIOD + 2) @(negedge clk);
    push_and_drain("press");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    mdl[0] = DUTY_INIT;
    mdl[1] = DUTY_INIT;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_duty0", int'(duty[DW-1:0]), DUTY_INIT);
    chk("rst_duty1", int'(duty[2*DW-1:DW]), DUTY_INIT);

    // Release: pwm high in the second cycle, aligned with period_start
    exp_q.push_back('{d0: 8'(DUTY_INIT), d1: 8'(DUTY_INIT)});
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_pwm0", int'(pwm[0]), 1);
`ifdef PWM_PHASE_STAGGER_EN
    chk("first_pwm1", int'(pwm[1]), 0);
`else
    chk("first_pwm1", int'(pwm[1]), 1);
`endif
    chk("first_period_start", int'(period_start), 1);
    push_and_drain("release");
    push_and_drain("steady");

    // Held increment, then one more to reach 9
    press(2'b01, 2'b00, 5);
    press(2'b01, 2'b00, 2);

    // Reset mid-operation at cnt=2 with duty0=9
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!period_start && w < 3 * PERIOD);
    if (w >= 3 * PERIOD) chk("sync_timeout", w, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_pwm0", int'(pwm[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_period_start", int'(period_start), 0);
    chk("async_rst_duty0", int'(duty[DW-1:0]), DUTY_INIT);
    repeat (2) @(negedge clk);
    mdl[0] = DUTY_INIT;
    mdl[1] = DUTY_INIT;
    exp_q.push_back('{d0: 8'(DUTY_INIT), d1: 8'(DUTY_INIT)});
    rst_n = 1'b1;
    push_and_drain("post_reset");

    // Saturation: 7, 9, 10, 10
    for (int i = 0; i < 4; i++) press(2'b01, 2'b00, 2);
    // Simultaneous inc+dec on channel 1
    press(2'b10, 2'b10, 3);
    // Channel 1 down to 0 through 1: 3, 1, 0, 0
    for (int i = 0; i < 4; i++) press(2'b00, 2'b10, 2);

    // Randomized presses on both channels
    for (int i = 0; i < 16; i++) begin
      logic [CH-1:0] im;
      logic [CH-1:0] dm;
      im = CH'($urandom_range(0, 3));
      dm = CH'($urandom_range(0, 3));
      press(im, dm, int'($urandom_range(2, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
